// File: rtl/burst_memory.sv
// Word-addressed main memory with 1/4/8/16-beat bursts, busy handshake and
// registered error pulse for misaligned or out-of-range requests.
module burst_memory #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DEPTH_WORDS = 262144,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h80020000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            access_size,
  input  logic                  rw,
  input  logic                  enable,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  error
);

  localparam int unsigned           STEP    = DATA_WIDTH / 8;
  localparam int unsigned           IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] STEP_A  = ADDR_WIDTH'(STEP);
  localparam logic [ADDR_WIDTH:0]   DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH_WORDS);

  typedef enum logic {IDLE, BURST} state_e;

  state_e                state_q, state_d;
  logic [3:0]            beats_left_q, beats_left_d;
  logic [IDX_W-1:0]      index_q, index_d;
  logic                  rw_q, rw_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  error_q, error_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [ADDR_WIDTH:0]   offset;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [ADDR_WIDTH:0]   last_idx;
  logic [3:0]            beats_m1;
  logic                  reject;
  logic                  do_beat;
  logic                  beat_rw;
  logic [IDX_W-1:0]      beat_idx;
  logic                  mem_we;

  always_comb begin
    unique case (access_size)
      2'b00:   beats_m1 = 4'd0;
      2'b01:   beats_m1 = 4'd3;
      2'b10:   beats_m1 = 4'd7;
      default: beats_m1 = 4'd15;
    endcase

    // Extra top bit of offset is the borrow: set when address is below the base.
    offset   = {1'b0, address} - {1'b0, BASE_ADDR};
    word_idx = offset[ADDR_WIDTH-1:0] / STEP_A;
    last_idx = {1'b0, word_idx} + (ADDR_WIDTH + 1)'(beats_m1);
    reject   = ((address % STEP_A) != '0) || offset[ADDR_WIDTH] || (last_idx >= DEPTH_A);

    state_d      = state_q;
    beats_left_d = beats_left_q;
    index_d      = index_q;
    rw_d         = rw_q;
    data_out_d   = data_out_q;
    error_d      = 1'b0;
    do_beat      = 1'b0;
    beat_rw      = rw_q;
    beat_idx     = index_q;

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          if (reject) begin
            error_d = 1'b1;
          end else begin
            // Beat 0 executes on the accepting edge itself.
            do_beat      = 1'b1;
            beat_rw      = rw;
            beat_idx     = word_idx[IDX_W-1:0];
            index_d      = word_idx[IDX_W-1:0] + IDX_W'(1);
            rw_d         = rw;
            beats_left_d = beats_m1;
            if (beats_m1 != 4'd0) state_d = BURST;
          end
        end
      end
      BURST: begin
        do_beat      = 1'b1;
        index_d      = index_q + IDX_W'(1);
        beats_left_d = beats_left_q - 4'd1;
        if (beats_left_q == 4'd1) state_d = IDLE;
      end
    endcase

    mem_we = do_beat && !beat_rw;
    if (do_beat && beat_rw) data_out_d = mem[beat_idx];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      index_q      <= '0;
      rw_q         <= 1'b0;
      data_out_q   <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      index_q      <= index_d;
      rw_q         <= rw_d;
      data_out_q   <= data_out_d;
      error_q      <= error_d;
    end
  end

  // Storage is deliberately outside the reset domain so its contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem[beat_idx] <= data_in;
  end

  assign busy     = (state_q == BURST);
  assign data_out = data_out_q;
  assign error    = error_q;

endmodule

// File: tb/tb_burst_memory.sv
// Directed self-checking bench for burst_memory with hand-computed expectations.
module tb_burst_memory;

  localparam int unsigned DEPTH = 262144;
  localparam logic [31:0] BASE  = 32'h80020000;

  logic        clock;
  logic        reset;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [1:0]  access_size;
  logic        rw;
  logic        enable;
  logic        busy;
  logic [31:0] data_out;
  logic        error;

  int unsigned vectors;
  int unsigned miscompares;

  logic [31:0] wbuf [16];
  logic [31:0] ebuf [16];

  burst_memory #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .address    (address),
    .data_in    (data_in),
    .access_size(access_size),
    .rw         (rw),
    .enable     (enable),
    .busy       (busy),
    .data_out   (data_out),
    .error      (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [1:0] sz, input int unsigned n,
                          input string tag);
    address = a; access_size = sz; rw = 1'b0; enable = 1'b1;
    for (int unsigned k = 0; k < n; k++) begin
      data_in = wbuf[k];
      tick();
      enable = 1'b0;
      check($sformatf("%s busy%0d", tag, k), 32'(busy), (k + 1 < n) ? 32'd1 : 32'd0);
      check($sformatf("%s err%0d", tag, k), 32'(error), 32'd0);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [1:0] sz, input int unsigned n,
                         input string tag);
    address = a; access_size = sz; rw = 1'b1; enable = 1'b1;
    for (int unsigned k = 0; k < n; k++) begin
      tick();
      enable = 1'b0;
      check($sformatf("%s d%0d", tag, k), data_out, ebuf[k]);
      check($sformatf("%s busy%0d", tag, k), 32'(busy), (k + 1 < n) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    logic [31:0] x_addr;
    logic [31:0] y_addr;
    logic [31:0] top_addr;

    vectors = 0; miscompares = 0;
    reset = 1'b1; enable = 1'b0; rw = 1'b1; address = BASE; data_in = '0; access_size = 2'b00;
    x_addr   = BASE + 32'h100;
    y_addr   = BASE + 32'h200;
    top_addr = BASE + (DEPTH - 8) * 4;

    tick(); tick();
    reset = 1'b0;
    check("rst busy", 32'(busy), 32'd0);
    check("rst dout", data_out, 32'd0);
    check("rst err", 32'(error), 32'd0);

    // Single write then single read.
    wbuf[0] = 32'hDEADBEEF;
    do_write(BASE, 2'b00, 1, "sw");
    ebuf[0] = 32'hDEADBEEF;
    do_read(BASE, 2'b00, 1, "sr");

    // 4-beat write then 4-beat read.
    wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222; wbuf[2] = 32'h33333333; wbuf[3] = 32'h44444444;
    do_write(BASE + 32'h10, 2'b01, 4, "w4");
    for (int i = 0; i < 4; i++) ebuf[i] = wbuf[i];
    do_read(BASE + 32'h10, 2'b01, 4, "r4");

    // Misaligned write rejected; valid read follows on the very next edge.
    address = BASE + 32'h2; rw = 1'b0; access_size = 2'b00; data_in = 32'h55555555; enable = 1'b1;
    tick();
    check("mis err", 32'(error), 32'd1);
    check("mis busy", 32'(busy), 32'd0);
    check("mis dout", data_out, 32'h44444444);
    address = BASE; rw = 1'b1;
    tick();
    enable = 1'b0;
    check("mis err clr", 32'(error), 32'd0);
    check("mis mem", data_out, 32'hDEADBEEF);

    // Below-base write rejected.
    address = 32'h8001FFFC; rw = 1'b0; data_in = 32'h66666666; enable = 1'b1;
    tick();
    enable = 1'b0;
    check("low err", 32'(error), 32'd1);
    check("low dout", data_out, 32'hDEADBEEF);
    tick();
    check("low err clr", 32'(error), 32'd0);

    // 8-beat burst ending exactly at the last word is accepted.
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hE0 + 32'(i);
    do_write(top_addr, 2'b10, 8, "top w8");

    // 16-beat burst from the same start overruns and is rejected whole.
    address = top_addr; rw = 1'b0; access_size = 2'b11; data_in = 32'h99999999; enable = 1'b1;
    tick();
    enable = 1'b0;
    check("ovr err", 32'(error), 32'd1);
    check("ovr busy", 32'(busy), 32'd0);
    check("ovr dout", data_out, 32'hDEADBEEF);

    // Single word just past the end is rejected.
    address = BASE + DEPTH * 4; rw = 1'b0; access_size = 2'b00; enable = 1'b1;
    tick();
    enable = 1'b0;
    check("end err", 32'(error), 32'd1);
    for (int i = 0; i < 8; i++) ebuf[i] = 32'hE0 + 32'(i);
    do_read(top_addr, 2'b10, 8, "top r8");

    // Back-to-back 8-beat write then read with no gap.
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hA0 + 32'(i);
    do_write(x_addr, 2'b10, 8, "b2b w");
    for (int i = 0; i < 8; i++) ebuf[i] = wbuf[i];
    do_read(x_addr, 2'b10, 8, "b2b r");

    // enable asserted with a write request during beat 3 of a read burst.
    address = x_addr; rw = 1'b1; access_size = 2'b10; enable = 1'b1;
    for (int unsigned k = 0; k < 8; k++) begin
      tick();
      enable = 1'b0;
      if (k == 2) begin
        address = x_addr; rw = 1'b0; access_size = 2'b00; data_in = 32'hFFFFFFFF; enable = 1'b1;
      end
      check($sformatf("ign d%0d", k), data_out, 32'hA0 + k);
      check($sformatf("ign busy%0d", k), 32'(busy), (k < 7) ? 32'd1 : 32'd0);
    end
    check("ign err", 32'(error), 32'd0);
    do_read(x_addr, 2'b10, 8, "ign chk");

    // Reset mid-burst: pre-fill, then abort a 16-beat write after beat 5.
    for (int i = 0; i < 16; i++) wbuf[i] = 32'h100 + 32'(i);
    do_write(y_addr, 2'b11, 16, "pre w16");
    address = y_addr; rw = 1'b0; access_size = 2'b11; enable = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      data_in = k;
      tick();
      enable = 1'b0;
    end
    check("abort busy pre", 32'(busy), 32'd1);
    check("abort dout pre", data_out, 32'hA7);
    data_in = 32'd6;
    reset = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort dout", data_out, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) ebuf[i] = (i <= 5) ? 32'(i) : 32'h100 + 32'(i);
    do_read(y_addr, 2'b11, 16, "abort r16");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/burst_memory.md
# burst_memory

Parametrised word-addressed main memory for the MIPS processor and its benches. It succeeds the single-word memory model and adds four things: configurable width, depth and base address; multi-word bursts selected by `access_size`; a `busy` handshake; and an `error` flag for misaligned or out-of-range requests. Both the fetch and the data-memory sides of the pipeline use it, as does the program loader that preloads `.x` images.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: word width in bits. Must be a multiple of 8.
- `ADDR_WIDTH`, default 32: byte-address width.
- `DEPTH_WORDS`, default 262144: number of words stored (1 MiB at 32-bit words).
- `BASE_ADDR`, default 32'h80020000: byte address of word 0.

Ports:
- `clock`, input, 1: sole clock. Everything is sampled on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `address`, input, ADDR_WIDTH: byte address of the first beat.
- `data_in`, input, DATA_WIDTH: write data for the current beat.
- `access_size`, input, 2: burst length. 00 = 1 beat, 01 = 4 beats, 10 = 8 beats, 11 = 16 beats.
- `rw`, input, 1: 0 = write, 1 = read.
- `enable`, input, 1: request strobe. Sampled only in IDLE.
- `busy`, output, 1: burst in progress. High while further beats remain.
- `data_out`, output, DATA_WIDTH: read data for the current beat.
- `error`, output, 1: one-cycle pulse when a request is rejected.

## Operation
- Word step `STEP` = DATA_WIDTH/8 bytes.
- Word index = (address − BASE_ADDR)/STEP.
- Storage array has DEPTH_WORDS entries. It is not cleared by reset.
- State machine has two states: IDLE and BURST.
- IDLE, `enable`=1 at an edge E0:
  - Reject the request if `address` is misaligned (address mod STEP ≠ 0), if address < BASE_ADDR, or if the last beat's index ≥ DEPTH_WORDS.
  - On rejection: `error`=1 for the cycle after E0, no memory access, stay in IDLE.
  - Otherwise, beat 0 executes at E0. The block latches `rw`, the index and beats_left = N−1.
  - Go to BURST if N>1, else stay in IDLE.
- BURST: each edge executes the next beat at index+1 and decrements beats_left. After the edge where beats_left reaches 0, return to IDLE.
- `address`, `rw` and `access_size` are ignored after E0.
- `enable` is ignored while in BURST. It is neither queued nor flagged.
- Write beat k: stores the `data_in` value sampled at edge Ek.
- Read beat k: `data_out` takes mem[index+k] at edge Ek and holds it until the next read beat or reset.
- Write beats leave `data_out` unchanged.
- Bursts never wrap. An overrun is rejected as a whole at E0.

## Timing
- Reset values: `busy`=0, `data_out`=0, `error`=0, state IDLE, beats_left=0.
- Reset mid-burst:
  - The burst aborts immediately.
  - Beats already written persist; remaining beats are never written.
  - `busy` falls asynchronously.
- Read latency is 1: data for beat k is valid after Ek. The consumer samples it at Ek+1.
- `busy` rises after E0 when N>1 and falls after E(N−1). Single-beat requests never raise `busy`.
- Back-to-back requests:
  - A new request is accepted at the first edge with `busy`=0, i.e. E(N) for the previous burst.
  - Zero bubble cycles.
- `error` is registered. It is high for exactly one cycle after a rejected E0. It does not stop a later valid request in the next cycle.
- Read-after-write to the same word in consecutive bursts returns the new data. Writes complete at their edge.

## Test plan
- Single write, then single read:
  - Write 32'hDEADBEEF to 32'h80020000 (access_size 00).
  - Then read the same address.
  - Required: `data_out`=DEADBEEF one edge after the read is accepted; `busy` never high.
- 4-beat write, then 4-beat read:
  - Write 11111111, 22222222, 33333333, 44444444 at 32'h80020010.
  - Read the same range with access_size 01.
  - Required: `busy` high for exactly 3 cycles per burst; `data_out` shows the four words on consecutive cycles.
- Rejections, each must pulse `error` once and leave memory and `data_out` unchanged:
  - Misaligned address 32'h80020002.
  - Address 32'h8001FFFC, below the base.
  - A 16-beat burst starting at index DEPTH_WORDS−8.
- `enable` during BURST:
  - Start an 8-beat read, then assert `enable` with `rw`=0 at beat 3.
  - Required: ignored; no write occurs; the burst finishes all 8 beats.
- Reset mid-burst:
  - Start a 16-beat write of values 0..15, then assert `reset` after beat 5.
  - Required: `busy`=0 and `data_out`=0 immediately; a readback shows words 0..5 written and words 6..15 holding their old contents.
- Back-to-back bursts:
  - Issue an 8-beat write, then an 8-beat read of the same range on the first edge with `busy`=0.
  - Required: no idle cycle between the bursts; the read returns the written data.
